// File: rtl/kb_pkg.sv
// Shared types and widths for the keyboard buffer read arbiter.
package kb_pkg;

  localparam int unsigned KB_CHAR_W = 7;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP,
    CLEAR
  } kb_state_e;

endpackage

// File: rtl/kb_rr_sel.sv
// Two-way round-robin selector: ptr picks the winner only when both ports request.
module kb_rr_sel (
  input  logic [1:0] req,
  input  logic       ptr,
  output logic       grant,
  output logic       any
);

  always_comb begin
    any   = |req;
    grant = (&req) ? ptr : req[1];
  end

endmodule

// File: rtl/kb_read_arbiter.sv
// Arbitrates two readers onto the keyboard character buffer, sequences
// buffer clears and counts buffer-full overruns.
module kb_read_arbiter
  import kb_pkg::*;
#(
  parameter int unsigned READ_LAT   = 1,
  parameter int unsigned CLR_CYCLES = 2,
  parameter int unsigned OVR_W      = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [1:0]           req_i,
  output logic [1:0]           ack_o,
  output logic [KB_CHAR_W-1:0] data_o,
  output logic                 empty_o,
  input  logic                 clr_req_i,
  output logic                 clr_busy_o,
  output logic [OVR_W-1:0]     ovr_cnt_o,
  input  logic                 KB_status,
  input  logic [KB_CHAR_W-1:0] KB_data,
  input  logic                 buf_full,
  output logic                 KB_read_en,
  output logic                 KB_clear
);

  localparam int unsigned LAT_W = 3;
  localparam int unsigned CLR_W = 4;

  kb_state_e            state_q, state_n;
  logic                 grant_q, grant_n;
  logic                 rr_ptr_q, rr_ptr_n;
  logic [LAT_W-1:0]     lat_q, lat_n;
  logic [CLR_W-1:0]     clr_cnt_q, clr_cnt_n;
  logic                 clr_pend_q, clr_pend_n;
  logic                 resp_empty_q, resp_empty_n;
  logic [KB_CHAR_W-1:0] cap_q, cap_n;
  logic                 buf_full_q;

  logic [1:0]           ack_n;
  logic [KB_CHAR_W-1:0] data_n;
  logic                 empty_n;
  logic                 busy_n;
  logic                 read_en_n;
  logic                 clear_n;
  logic [OVR_W-1:0]     ovr_n;

  logic sel_grant;
  logic sel_any;

  kb_rr_sel u_rr_sel (
    .req   (req_i),
    .ptr   (rr_ptr_q),
    .grant (sel_grant),
    .any   (sel_any)
  );

  // Next-state, datapath and registered-output values
  always_comb begin
    state_n      = state_q;
    grant_n      = grant_q;
    rr_ptr_n     = rr_ptr_q;
    lat_n        = lat_q;
    clr_cnt_n    = clr_cnt_q;
    clr_pend_n   = clr_pend_q;
    resp_empty_n = resp_empty_q;
    cap_n        = cap_q;

    if (clr_req_i && (state_q != CLEAR)) begin
      clr_pend_n = 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (clr_pend_q) begin
          // Entering CLEAR absorbs any request arriving this same cycle
          clr_pend_n = 1'b0;
          clr_cnt_n  = CLR_W'(CLR_CYCLES - 1);
          state_n    = CLEAR;
        end else if (sel_any) begin
          grant_n  = sel_grant;
          rr_ptr_n = ~sel_grant;
          if (KB_status) begin
            resp_empty_n = 1'b0;
            state_n      = ISSUE;
          end else begin
            resp_empty_n = 1'b1;
            cap_n        = '0;
            state_n      = RESP;
          end
        end
      end
      ISSUE: begin
        lat_n   = LAT_W'(READ_LAT - 1);
        state_n = WAIT;
      end
      WAIT: begin
        if (lat_q == '0) begin
          cap_n   = KB_data;
          state_n = RESP;
        end else begin
          lat_n = lat_q - 1'b1;
        end
      end
      RESP: begin
        state_n = IDLE;
      end
      CLEAR: begin
        if (clr_cnt_q == '0) begin
          state_n = IDLE;
        end else begin
          clr_cnt_n = clr_cnt_q - 1'b1;
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase

    ack_n     = 2'b00;
    data_n    = data_o;
    empty_n   = empty_o;
    if (state_q == RESP) begin
      ack_n   = grant_q ? 2'b10 : 2'b01;
      data_n  = cap_q;
      empty_n = resp_empty_q;
    end
    read_en_n = (state_q == ISSUE);
    clear_n   = (state_q == CLEAR);
    busy_n    = clr_pend_n || (state_n == CLEAR) || (state_q == CLEAR);

    ovr_n = ovr_cnt_o;
    if (buf_full && !buf_full_q && (ovr_cnt_o != {OVR_W{1'b1}})) begin
      ovr_n = ovr_cnt_o + 1'b1;
    end
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      grant_q      <= 1'b0;
      rr_ptr_q     <= 1'b0;
      lat_q        <= '0;
      clr_cnt_q    <= '0;
      clr_pend_q   <= 1'b0;
      resp_empty_q <= 1'b0;
      cap_q        <= '0;
      buf_full_q   <= 1'b0;
      ack_o        <= 2'b00;
      data_o       <= '0;
      empty_o      <= 1'b0;
      clr_busy_o   <= 1'b0;
      ovr_cnt_o    <= '0;
      KB_read_en   <= 1'b0;
      KB_clear     <= 1'b0;
    end else begin
      state_q      <= state_n;
      grant_q      <= grant_n;
      rr_ptr_q     <= rr_ptr_n;
      lat_q        <= lat_n;
      clr_cnt_q    <= clr_cnt_n;
      clr_pend_q   <= clr_pend_n;
      resp_empty_q <= resp_empty_n;
      cap_q        <= cap_n;
      buf_full_q   <= buf_full;
      ack_o        <= ack_n;
      data_o       <= data_n;
      empty_o      <= empty_n;
      clr_busy_o   <= busy_n;
      ovr_cnt_o    <= ovr_n;
      KB_read_en   <= read_en_n;
      KB_clear     <= clear_n;
    end
  end

endmodule
